// File: rtl/hms_seg_scan.sv
// hms_seg_scan -- multiplexed six-digit HH:MM:SS seven-segment scanner.
//
// Each digit is driven for SCAN_DIV clocks, scanning s ones, s tens, m ones,
// m tens, h ones and h tens. A full frame therefore lasts 6*SCAN_DIV clocks.
// Field values are captured into shadow registers only at frame boundaries,
// so a frame is never torn. A free-running blink counter provides a
// visible/blank phase that is used for per-field blinking and alarm flash.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   en          display enable (0 = dark, counters held cleared)
//   in_h/m/s    6-bit binary field values (0..63)
//   blink_mask  per-field blink select: [2]=h, [1]=m, [0]=s
//   flash       blank every digit during the blank phase
//   dig         one-hot digit select, bit0 = s ones .. bit5 = h tens
//   seg         segments a..g on bits 0..6, active high
//   dp          decimal point, lit on m ones and h ones as field separator
module hms_seg_scan #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [5:0] in_h,
  input  logic [5:0] in_m,
  input  logic [5:0] in_s,
  input  logic [2:0] blink_mask,
  input  logic       flash,
  output logic [5:0] dig,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [5:0]    shadow_h, shadow_m, shadow_s;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic          div_wrap, frame_wrap, blink_wrap;
  logic [5:0]    field_p0;
  logic          field_blink_p0;
  logic [3:0]    digit_p0;
  logic          blank_p0;
  logic [5:0]    dig_p0;
  logic [6:0]    seg_p0;
  logic          dp_p0;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Stage p0: decode the digit addressed by the current idx from the shadows.
  always_comb begin
    div_wrap   = (div_cnt == DIV_LAST);
    frame_wrap = div_wrap && (idx == 3'd5);
    blink_wrap = (blink_cnt == BLINK_LAST);

    field_p0       = shadow_h;
    field_blink_p0 = blink_mask[2];
    case (idx)
      3'd0, 3'd1: begin
        field_p0       = shadow_s;
        field_blink_p0 = blink_mask[0];
      end
      3'd2, 3'd3: begin
        field_p0       = shadow_m;
        field_blink_p0 = blink_mask[1];
      end
      default: begin
        field_p0       = shadow_h;
        field_blink_p0 = blink_mask[2];
      end
    endcase

    // Odd scan positions are the tens digit of their field.
    digit_p0 = idx[0] ? tens_of(field_p0) : ones_of(field_p0);
    blank_p0 = phase && (flash || field_blink_p0);
    dig_p0   = 6'b000001 << idx;
    seg_p0   = blank_p0 ? 7'h00 : seg7(digit_p0);
    dp_p0    = !blank_p0 && ((idx == 3'd2) || (idx == 3'd4));
  end

  // Stage p1: registered scan state and display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      idx       <= 3'd0;
      shadow_h  <= 6'd0;
      shadow_m  <= 6'd0;
      shadow_s  <= 6'd0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      dig       <= 6'd0;
      seg       <= 7'd0;
      dp        <= 1'b0;
    end else if (!en) begin
      // Track the inputs while dark so the first enabled frame is current.
      div_cnt   <= '0;
      idx       <= 3'd0;
      shadow_h  <= in_h;
      shadow_m  <= in_m;
      shadow_s  <= in_s;
      blink_cnt <= '0;
      phase     <= 1'b0;
      dig       <= 6'd0;
      seg       <= 7'd0;
      dp        <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      if (frame_wrap) begin
        shadow_h <= in_h;
        shadow_m <= in_m;
        shadow_s <= in_s;
      end
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap) begin
        phase <= ~phase;
      end
      dig <= dig_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: doc/hms_seg_scan.md
HMS_SEG_SCAN -- requirements
Module: hms_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning clk cycles each digit is driven (legal value ≥2).
REQ-002 SHALL have parameter BLINK_DIV, default 32, meaning clk cycles per blink half-period (legal value ≥2).
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  display enable; 0 = display dark.
REQ-006 in_h, in_m, in_s  input  6 each  unsigned binary field values, 0..63 accepted.
REQ-007 blink_mask  input  3  field blink select: bit2 = h, bit1 = m, bit0 = s.
REQ-008 flash  input  1  alarm flash; blanks all digits during the off phase.
REQ-009 dig  output  6  one-hot active-high digit select: bit0 = s ones, bit1 = s tens, bit2 = m ones, bit3 = m tens, bit4 = h ones, bit5 = h tens.
REQ-010 seg  output  7  active-high segments, bit0 = a .. bit6 = g.
REQ-011 dp  output  1  active-high decimal point (field separator).

Function
REQ-012 Internal state SHALL be: div_cnt (0..SCAN_DIV-1), idx (0..5), shadow_h/m/s (6b each), blink_cnt (0..BLINK_DIV-1), phase (1b).
REQ-013 When en=1, div_cnt SHALL increment each cycle and wrap at SCAN_DIV-1 to 0.
REQ-014 On a div_cnt wrap, idx SHALL advance by 1, wrapping from 5 to 0.
REQ-015 Shadow registers SHALL load in_h/m/s on the edge where idx wraps 5→0, and on every edge while en=0.
REQ-016 Shadow registers SHALL NOT load at any other time; input changes mid-frame SHALL NOT affect the current frame.
REQ-017 When en=1, blink_cnt SHALL increment every cycle; on wrap at BLINK_DIV-1, phase SHALL toggle.
REQ-018 phase=0 SHALL be the visible phase; phase=1 SHALL be the blank phase.
REQ-019 Digit value SHALL be computed as follows: tens = field/10, ones = field%10, over the full 0..63 range; tens value 6 SHALL be displayed as the digit 6.
REQ-020 Segment encoding (hex, g..a) SHALL be: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
REQ-021 dp SHALL be 1 when idx=2 or idx=4, and 0 otherwise.
REQ-022 A digit SHALL be blanked (seg=0, dp=0, dig still driven) when phase=1 and (flash=1, or the blink_mask bit of the digit's field is 1).
REQ-023 dig, seg and dp SHALL be registered, computed from the pre-edge idx, shadow, phase, blink_mask, flash and en; latency is 1 cycle from internal state.
REQ-024 With en=0: on each edge div_cnt, idx, blink_cnt and phase SHALL clear to 0, and dig, seg and dp SHALL register 0.
REQ-025 On the first enabled cycle after en=0, the output SHALL show the newly shadowed input with no stale frame.
REQ-026 blink_mask and flash SHALL take effect on the next edge, without waiting for a frame boundary.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force: dig=0, seg=0, dp=0, div_cnt=0, idx=0, blink_cnt=0, phase=0, shadow=0.
REQ-028 After reset release with en=1, the first edge SHALL register dig=000001, seg=3F.
REQ-029 After reset release, frame 0 SHALL display 00:00:00; the inputs SHALL appear from frame 1 (cycle 25 with default parameters).
REQ-030 Reset asserted mid-frame SHALL abort the frame; there SHALL be no partial-state carry-over.

Verification
REQ-031 Scan: reset, en=1, in=12:34:56 held, then one frame -> from cycle 25, 4 cycles each: dig 000001/7D; 000010/6D; 000100/66 dp=1; 001000/4F; 010000/5B dp=1; 100000/06; frame period 24 cycles.
REQ-032 Tearing: in_s 56→07 while idx=2 -> rest of that frame still shows 5/6; the next frame shows s tens 3F, s ones 07.
REQ-033 Range: in=63:00:09 -> h tens 7D, h ones 4F, m digits 3F, s ones 6F.
REQ-034 Blink: blink_mask=010, in=12:34:56 -> with phase=1 (cycles 33-64 after release), dig cycles normally, seg=0 and dp=0 on idx 2/3, other digits unchanged; flash=1 -> all seg/dp 0 during phase=1, normal during phase=0.
REQ-035 Enable: en=0 for 10 cycles mid-frame -> dig=seg=dp=0 one edge later; re-enable with in=01:02:03 -> first frame shows 01:02:03 starting at dig=000001/4F.
REQ-036 Async reset: pulse reset between clock edges while dig=001000 -> outputs 0 before the next edge; counters restart at idx=0.
